// File: rtl/image_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : image_ram_writer
// Summary  : Loads a width/height header and a grayscale pixel stream into the
//            frame RAM port A, four pixels per word with byte enables.
// Revision : 1.0 - initial release
// ============================================================================
module image_ram_writer #(
  parameter int                ADDR_W       = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDRESS = 17'h4,
  parameter logic [31:0]       MAX_PIXELS   = 32'd100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] address_a,
  output logic [31:0]       data_a,
  output logic [3:0]        byteena_a,
  output logic              wren_a,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WR_W  = 3'd2,
    ST_WR_H  = 3'd3,
    ST_PIX   = 3'd4,
    ST_FIN   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ready, w_ready_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_data, w_data_nxt;
  logic [3:0]        r_be, w_be_nxt;
  logic              r_wren, w_wren_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic [1:0]        r_hdr_cnt, w_hdr_cnt_nxt;
  logic [15:0]       r_width, w_width_nxt;
  logic [15:0]       r_height, w_height_nxt;
  logic [31:0]       r_npix, w_npix_nxt;
  logic [31:0]       r_idx, w_idx_nxt;
  logic [31:0]       r_acc, w_acc_nxt;
  logic [3:0]        r_mask, w_mask_nxt;
  logic              w_take;
  logic              w_last;

  assign w_take = s_valid & r_ready;
  assign w_last = (r_idx == (r_npix - 32'd1));

  always_comb begin
    w_state_nxt   = r_state;
    w_ready_nxt   = 1'b0;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_be_nxt      = r_be;
    w_wren_nxt    = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_error_nxt   = r_error;
    w_hdr_cnt_nxt = r_hdr_cnt;
    w_width_nxt   = r_width;
    w_height_nxt  = r_height;
    w_npix_nxt    = r_npix;
    w_idx_nxt     = r_idx;
    w_acc_nxt     = r_acc;
    w_mask_nxt    = r_mask;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state_nxt   = ST_HDR;
          w_ready_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
          w_error_nxt   = 1'b0;
          w_hdr_cnt_nxt = 2'd0;
          w_idx_nxt     = 32'd0;
          w_mask_nxt    = 4'b0000;
        end
      end
      ST_HDR: begin
        w_ready_nxt = 1'b1;
        if (w_take) begin
          w_hdr_cnt_nxt = r_hdr_cnt + 2'd1;
          case (r_hdr_cnt)
            2'd0: w_width_nxt[7:0]   = s_data;
            2'd1: w_width_nxt[15:8]  = s_data;
            2'd2: w_height_nxt[7:0]  = s_data;
            default: begin
              // Width is complete here, so its header word goes out next cycle.
              w_height_nxt[15:8] = s_data;
              w_state_nxt        = ST_WR_W;
              w_ready_nxt        = 1'b0;
              w_wren_nxt         = 1'b1;
              w_addr_nxt         = '0;
              w_data_nxt         = {16'h0, r_width};
              w_be_nxt           = 4'b1111;
            end
          endcase
        end
      end
      ST_WR_W: begin
        w_state_nxt = ST_WR_H;
        w_wren_nxt  = 1'b1;
        w_addr_nxt  = ADDR_W'(1);
        w_data_nxt  = {16'h0, r_height};
        w_be_nxt    = 4'b1111;
        w_npix_nxt  = {16'h0, r_width} * {16'h0, r_height};
      end
      ST_WR_H: begin
        if (r_npix > MAX_PIXELS) begin
          w_state_nxt = ST_ERROR;
          w_error_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else if (r_npix == 32'd0) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_PIX;
          w_ready_nxt = 1'b1;
        end
      end
      ST_PIX: begin
        w_ready_nxt = 1'b1;
        if (w_take) begin
          w_acc_nxt[{r_idx[1:0], 3'b000} +: 8] = s_data;
          w_mask_nxt = r_mask | (4'b0001 << r_idx[1:0]);
          w_idx_nxt  = r_idx + 32'd1;
          if ((r_idx[1:0] == 2'd3) || w_last) begin
            w_wren_nxt = 1'b1;
            w_addr_nxt = BASE_ADDRESS + ADDR_W'(r_idx >> 2);
            w_data_nxt = w_acc_nxt;
            w_be_nxt   = w_mask_nxt;
            w_mask_nxt = 4'b0000;
          end
          if (w_last) begin
            w_state_nxt = ST_FIN;
            w_ready_nxt = 1'b0;
          end
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_addr    <= '0;
      r_data    <= 32'd0;
      r_be      <= 4'b0000;
      r_wren    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_hdr_cnt <= 2'd0;
      r_width   <= 16'd0;
      r_height  <= 16'd0;
      r_npix    <= 32'd0;
      r_idx     <= 32'd0;
      r_acc     <= 32'd0;
      r_mask    <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= w_ready_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_be      <= w_be_nxt;
      r_wren    <= w_wren_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_hdr_cnt <= w_hdr_cnt_nxt;
      r_width   <= w_width_nxt;
      r_height  <= w_height_nxt;
      r_npix    <= w_npix_nxt;
      r_idx     <= w_idx_nxt;
      r_acc     <= w_acc_nxt;
      r_mask    <= w_mask_nxt;
    end
  end

  assign s_ready   = r_ready;
  assign address_a = r_addr;
  assign data_a    = r_data;
  assign byteena_a = r_be;
  assign wren_a    = r_wren;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_image_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_ram_writer
// Summary  : Directed loads of image_ram_writer checked against a write-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_ram_writer;

  typedef struct packed {
    logic [16:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;
  typedef wr_t        wr_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [16:0] address_a;
  logic [31:0] data_a;
  logic [3:0]  byteena_a;
  logic        wren_a;
  logic        busy;
  logic        done;
  logic        error;

  image_ram_writer dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .address_a(address_a), .data_a(data_a),
    .byteena_a(byteena_a), .wren_a(wren_a), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    cyc = 0;
  int    last_wr = 0;
  int    n_done = 0;
  int    done_lag = 0;
  wr_q_t exp_q;
  wr_t   cmp_e;
  logic [31:0] cmp_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m[i*8 +: 8] = 8'hff;
    return m;
  endfunction

  // Expected RAM write list: two header words, then pixels packed 4 per word.
  function automatic wr_q_t model(input logic [15:0] w, input logic [15:0] h, input byte_q_t pix);
    wr_q_t       q;
    logic [31:0] npix;
    logic [31:0] word;
    logic [3:0]  m;
    int          lane;
    npix = {16'h0, w} * {16'h0, h};
    q.push_back('{17'd0, {16'h0, w}, 4'hf});
    q.push_back('{17'd1, {16'h0, h}, 4'hf});
    word = 32'h0;
    m = 4'h0;
    if (npix <= 32'd100000 && npix != 32'd0) begin
      foreach (pix[i]) begin
        lane = i % 4;
        word[lane*8 +: 8] = pix[i];
        m[lane] = 1'b1;
        if (lane == 3 || i == int'(npix) - 1) begin
          q.push_back('{17'(4 + i / 4), word, m});
          m = 4'h0;
        end
      end
    end
    return q;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (done) begin
        n_done++;
        done_lag = cyc - last_wr;
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
      if (wren_a) begin
        last_wr = cyc;
        chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          cmp_e = exp_q.pop_front();
          cmp_m = lane_mask(cmp_e.be);
          chk("ram_write", {11'h0, address_a, data_a & cmp_m, byteena_a},
                           {11'h0, cmp_e.a, cmp_e.d & cmp_m, cmp_e.be});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("handshake", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_and_header(input logic [15:0] w, input logic [15:0] h);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_error_done_after_start", 64'({busy, error, done}), 64'b100);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(h[7:0]);
    send_byte(h[15:8]);
  endtask

  task automatic do_load(input logic [15:0] w, input logic [15:0] h, input byte_q_t pix,
                         input bit toggle);
    int          d0;
    bit          is_err;
    bit          seen;
    logic [31:0] npix;
    npix   = {16'h0, w} * {16'h0, h};
    is_err = npix > 32'd100000;
    d0     = n_done;
    exp_q  = model(w, h, pix);
    pulse_start_and_header(w, h);
    if (!is_err) begin
      foreach (pix[i]) begin
        send_byte(pix[i]);
        if (toggle) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
    end
    s_valid = 1'b0;
    for (int i = 0; i < 40 && n_done == d0 && !error; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    if (is_err) begin
      chk("error_state", 64'({error, busy, s_ready}), 64'b100);
      seen = 1'b0;
      s_data  = 8'h5a;
      s_valid = 1'b1;
      repeat (4) begin
        @(negedge clk);
        seen |= s_ready;
      end
      @(posedge clk);
      #1 s_valid = 1'b0;
      chk("ready_low_in_error", 64'(seen), 64'd0);
    end else begin
      chk("done_pulses_once", 64'(n_done - d0), 64'd1);
      chk("idle_after_done", 64'({error, busy, s_ready, wren_a}), 64'd0);
      if (npix != 32'd0) chk("done_after_last_write", 64'(done_lag), 64'd1);
    end
    chk("writes_all_seen", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    byte_q_t pq;
    byte_q_t none;
    wr_q_t   mq;

    #1 rst = 1'b1;
    #1 chk("reset_outputs", 64'({s_ready, address_a, data_a, byteena_a, wren_a, busy, done, error}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("idle_outputs", 64'({s_ready, address_a, data_a, byteena_a, wren_a, busy, done, error}), 64'd0);

    pq = '{8'h11, 8'h22, 8'h33, 8'h44};
    mq = model(16'd2, 16'd2, pq);
    chk("model_pin_hdr", 64'(mq[0]), 64'({17'h0, 32'h00000002, 4'hf}));
    chk("model_pin_word", 64'(mq[2]), 64'({17'h4, 32'h44332211, 4'hf}));
    do_load(16'd2, 16'd2, pq, 1'b0);

    pq = '{8'haa, 8'hbb, 8'hcc};
    mq = model(16'd3, 16'd1, pq);
    chk("model_pin_partial", 64'({mq[2].a, mq[2].be, mq[2].d[23:0]}), 64'({17'h4, 4'b0111, 24'hccbbaa}));
    do_load(16'd3, 16'd1, pq, 1'b0);

    pq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    mq = model(16'd8, 16'd1, pq);
    chk("model_pin_word5", 64'(mq[3]), 64'({17'h5, 32'h08070605, 4'hf}));
    do_load(16'd8, 16'd1, pq, 1'b1);

    pq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
    do_load(16'd3, 16'd3, pq, 1'b0);

    do_load(16'h0190, 16'h0190, none, 1'b0);
    do_load(16'd0, 16'd5, none, 1'b0);

    // Abort mid-word: only the two header words may ever reach the RAM.
    exp_q = model(16'd2, 16'd2, none);
    pulse_start_and_header(16'd2, 16'd2);
    send_byte(8'hab);
    send_byte(8'hcd);
    s_valid = 1'b0;
    #3 rst = 1'b1;
    #1 chk("async_reset_mid_load", 64'({s_ready, address_a, data_a, byteena_a, wren_a, busy, done, error}), 64'd0);
    chk("header_writes_before_abort", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    pq = '{8'h55, 8'h66, 8'h77, 8'h88};
    do_load(16'd2, 16'd2, pq, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
